// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, constants and binary32 layout for the FP normalize/round stage
package fp_pkg;
   localparam int SIZE_MANTISSA = 28;
   localparam int SIZE_EXPONENT = 8;
   localparam int SIZE_LZC      = 5;
   localparam int EXP_BIAS      = 127;
   localparam int EXP_MAX       = 255;

   // Working mantissa layout: hidden | 23-bit fraction | guard | round | 2 sticky bits
   localparam int MANT_HIDDEN = 27;
   localparam int FRAC_MSB    = 26;
   localparam int FRAC_LSB    = 4;
   localparam int GUARD_BIT   = 3;
   localparam int ROUND_BIT   = 2;
   localparam int STICKY_MSB  = 1;

   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;
endpackage

// File: rtl/norm_lzc.sv
// rtl/norm_lzc.sv - combinational leading-zero counter for the 28-bit working mantissa
// An all-zero input yields count 28 together with all_zero_o.
module norm_lzc
   import fp_pkg::*;
(
   input  logic [SIZE_MANTISSA-1:0] mant_i,
   output logic [SIZE_LZC-1:0]      count_o,
   output logic                     all_zero_o
);
   logic found;

   always_comb begin
      count_o = '0;
      found   = 1'b0;
      for (int i = SIZE_MANTISSA - 1; i >= 0; i--) begin
         if (!found) begin
            if (mant_i[i]) found = 1'b1;
            else           count_o = count_o + SIZE_LZC'(1);
         end
      end
      all_zero_o = ~found;
   end
endmodule

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - 2-stage normalize, round-to-nearest-even and pack for the binary32 adder
// FP_NORM_STICKY_FLAGS_EN adds i_flag_clr and the o_sticky_ovf/o_sticky_unf accumulators.
module fp_normalize_round
   import fp_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic                     i_sign,
   input  logic [SIZE_EXPONENT-1:0] i_exponent,
   input  logic [SIZE_MANTISSA-1:0] i_mantissa,
   input  logic                     i_overflow,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [31:0]              o_result,
   output logic                     o_flag_ovf,
   output logic                     o_flag_unf,
`ifdef FP_NORM_STICKY_FLAGS_EN
   input  logic                     i_flag_clr,
   output logic                     o_sticky_ovf,
   output logic                     o_sticky_unf,
`endif
   output logic                     o_flag_zero
);
   logic                     adv2;
   logic [SIZE_LZC-1:0]      lz;
   logic                     mant_zero;

   logic                     s1_valid_q, s1_valid_d;
   logic                     s1_sign_q;
   logic                     s1_zero_q, s1_zero_d;
   logic [FRAC_MSB:0]        s1_mant_q;
   logic [SIZE_MANTISSA-1:0] s1_mant_d;
   logic signed [9:0]        s1_exp_q, s1_exp_d;

   logic                     s2_valid_q;
   fp32_t                    s2_res_q, s2_res_d;
   logic                     s2_ovf_q, s2_ovf_d, s2_unf_q, s2_unf_d, s2_zero_q, s2_zero_d;

   logic                     round_up;
   logic [23:0]              frac_sum;
   logic signed [9:0]        exp_r;

   assign adv2    = !s2_valid_q | i_ready;
   assign o_ready = !s1_valid_q | adv2;

   norm_lzc u_lzc (
      .mant_i     (i_mantissa),
      .count_o    (lz),
      .all_zero_o (mant_zero)
   );

   // Stage 1: carry-out takes a 1-bit right shift with the dropped bit folded into sticky
   always_comb begin
      s1_valid_d = o_ready ? i_valid : s1_valid_q;
      s1_zero_d  = mant_zero & !i_overflow;
      if (i_overflow) begin
         s1_mant_d = {1'b1, i_mantissa[MANT_HIDDEN:2], |i_mantissa[STICKY_MSB:0]};
         s1_exp_d  = $signed({2'b00, i_exponent}) + 10'sd1;
      end else begin
         s1_mant_d = i_mantissa << lz;
         s1_exp_d  = $signed({2'b00, i_exponent}) - $signed({5'b00000, lz});
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_mant_q  <= '0;
         s1_exp_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (o_ready && i_valid) begin
            s1_sign_q <= i_sign;
            s1_zero_q <= s1_zero_d;
            s1_mant_q <= s1_mant_d[FRAC_MSB:0];
            s1_exp_q  <= s1_exp_d;
         end
      end
   end

   // Stage 2: round-to-nearest-even, then range check and pack
   always_comb begin
      round_up = s1_mant_q[GUARD_BIT] &
                 (s1_mant_q[ROUND_BIT] | (|s1_mant_q[STICKY_MSB:0]) | s1_mant_q[FRAC_LSB]);
      frac_sum = {1'b0, s1_mant_q[FRAC_MSB:FRAC_LSB]} + {23'b0, round_up};
      exp_r    = s1_exp_q + $signed({9'b0, frac_sum[23]});
      s2_res_d  = '{sign: s1_sign_q, exp: exp_r[7:0], frac: frac_sum[22:0]};
      s2_ovf_d  = 1'b0;
      s2_unf_d  = 1'b0;
      s2_zero_d = 1'b0;
      if (s1_zero_q) begin
         s2_res_d  = '0;
         s2_zero_d = 1'b1;
      end else if (exp_r >= $signed(10'(EXP_MAX))) begin
         s2_res_d = fp32_t'(s1_sign_q ? NEG_INF : POS_INF);
         s2_ovf_d = 1'b1;
      end else if (exp_r <= 10'sd0) begin
         s2_res_d  = '{sign: s1_sign_q, exp: 8'h00, frac: 23'h0};
         s2_unf_d  = 1'b1;
         s2_zero_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_ovf_q   <= 1'b0;
         s2_unf_q   <= 1'b0;
         s2_zero_q  <= 1'b0;
      end else if (adv2) begin
         s2_valid_q <= s1_valid_q;
         s2_res_q   <= s2_res_d;
         s2_ovf_q   <= s2_ovf_d;
         s2_unf_q   <= s2_unf_d;
         s2_zero_q  <= s2_zero_d;
      end
   end

   assign o_valid     = s2_valid_q;
   assign o_result    = s2_res_q;
   assign o_flag_ovf  = s2_ovf_q;
   assign o_flag_unf  = s2_unf_q;
   assign o_flag_zero = s2_zero_q;

`ifdef FP_NORM_STICKY_FLAGS_EN
   logic sticky_ovf_q, sticky_unf_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sticky_ovf_q <= 1'b0;
         sticky_unf_q <= 1'b0;
      end else if (i_flag_clr) begin
         sticky_ovf_q <= 1'b0;
         sticky_unf_q <= 1'b0;
      end else if (s2_valid_q && i_ready) begin
         sticky_ovf_q <= sticky_ovf_q | s2_ovf_q;
         sticky_unf_q <= sticky_unf_q | s2_unf_q;
      end
   end

   assign o_sticky_ovf = sticky_ovf_q;
   assign o_sticky_unf = sticky_unf_q;
`endif
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb/tb_fp_normalize_round.sv - directed self-checking bench for fp_normalize_round
module tb_fp_normalize_round;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0, i_sign = 1'b0, i_overflow = 1'b0, i_ready = 1'b1;
   logic [7:0]  i_exponent = '0;
   logic [27:0] i_mantissa = '0;
   logic        o_ready, o_valid, o_flag_ovf, o_flag_unf, o_flag_zero;
   logic [31:0] o_result;
`ifdef FP_NORM_STICKY_FLAGS_EN
   logic        i_flag_clr = 1'b0;
   logic        o_sticky_ovf, o_sticky_unf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  fl;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   fp_normalize_round dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_sign      (i_sign),
      .i_exponent  (i_exponent),
      .i_mantissa  (i_mantissa),
      .i_overflow  (i_overflow),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_result    (o_result),
      .o_flag_ovf  (o_flag_ovf),
      .o_flag_unf  (o_flag_unf),
`ifdef FP_NORM_STICKY_FLAGS_EN
      .i_flag_clr  (i_flag_clr),
      .o_sticky_ovf(o_sticky_ovf),
      .o_sticky_unf(o_sticky_unf),
`endif
      .o_flag_zero (o_flag_zero)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Drive one input beat and hold it until accepted; expected flags are {ovf, unf, zero}
   task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m, input logic ov,
                       input logic [31:0] res, input logic [2:0] fl);
      logic ok;
      int   n;
      i_sign = s; i_exponent = e; i_mantissa = m; i_overflow = ov; i_valid = 1'b1;
      exp_q.push_back('{res: res, fl: fl});
      n = 0;
      do begin
         @(negedge clk) ok = o_ready;
         @(posedge clk) #1;
         n++;
      end while (!ok && n < 50);
      if (!ok) check("send_timeout", 32'(ok), 32'd1);
      i_valid = 1'b0;
   endtask

   logic        stall_prev = 1'b0;
   logic [31:0] held_res = '0;
   int          post_rst_outs = 0;
   logic        count_post = 1'b0;

   always @(negedge clk) begin
      if (!rst) begin
         if (stall_prev && o_valid) check("hold_stable", o_result, held_res);
         if (count_post && o_valid) post_rst_outs++;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'(o_valid), 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("result", o_result, e.res);
               check("flags", {29'b0, o_flag_ovf, o_flag_unf, o_flag_zero}, {29'b0, e.fl});
            end
         end
         stall_prev = o_valid & !i_ready;
         held_res   = o_result;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_o_ready", 32'(o_ready), 32'd1);
      check("rst_o_result", o_result, 32'h0);
      check("rst_flags", {29'b0, o_flag_ovf, o_flag_unf, o_flag_zero}, 32'd0);
      @(posedge clk) #1;

      // 1.0 + 1.0 with latency probe
      i_sign = 1'b0; i_exponent = 8'd127; i_mantissa = 28'h0; i_overflow = 1'b1; i_valid = 1'b1;
      exp_q.push_back('{res: 32'h4000_0000, fl: 3'b000});
      @(posedge clk) #1 i_valid = 1'b0;
      @(negedge clk) check("lat_cycle1", 32'(o_valid), 32'd0);
      @(negedge clk) check("lat_cycle2", 32'(o_valid), 32'd1);
      @(posedge clk) #1;

      send(1'b0, 8'd127, 28'h400_0000, 1'b0, 32'h3F00_0000, 3'b000);
      send(1'b1, 8'd100, 28'h000_0000, 1'b0, 32'h0000_0000, 3'b001);
      send(1'b0, 8'd127, 28'hFFF_FFF8, 1'b0, 32'h4000_0000, 3'b000);
      send(1'b0, 8'd127, 28'hFFF_FFE8, 1'b0, 32'h3FFF_FFFE, 3'b000);
      send(1'b0, 8'd254, 28'h000_0000, 1'b1, 32'h7F80_0000, 3'b100);
      send(1'b1, 8'd254, 28'h000_0000, 1'b1, 32'hFF80_0000, 3'b100);
      send(1'b0, 8'd1,   28'h400_0000, 1'b0, 32'h0000_0000, 3'b011);
      send(1'b1, 8'd1,   28'h400_0000, 1'b0, 32'h8000_0000, 3'b011);
      send(1'b0, 8'd127, 28'h800_0008, 1'b0, 32'h3F80_0000, 3'b000);
      send(1'b0, 8'd127, 28'h800_000C, 1'b0, 32'h3F80_0001, 3'b000);
      send(1'b0, 8'd127, 28'h800_0018, 1'b0, 32'h3F80_0002, 3'b000);
      send(1'b0, 8'd127, 28'h000_0010, 1'b0, 32'h3400_0000, 3'b000);
      send(1'b0, 8'd127, 28'h000_0011, 1'b1, 32'h4000_0001, 3'b000);
      send(1'b0, 8'd254, 28'hFFF_FFF8, 1'b0, 32'h7F80_0000, 3'b100);

      // Back-to-back stream with a 3-cycle downstream stall
      fork
         begin
            i_ready = 1'b0;
            @(posedge clk);
            @(posedge clk);
            @(negedge clk) check("stall_o_ready", 32'(o_ready), 32'd0);
            @(posedge clk) #1 i_ready = 1'b1;
         end
         begin
            send(1'b0, 8'd127, 28'h000_0000, 1'b1, 32'h4000_0000, 3'b000);
            send(1'b0, 8'd127, 28'h400_0000, 1'b0, 32'h3F00_0000, 3'b000);
            send(1'b1, 8'd130, 28'h800_0000, 1'b0, 32'hC100_0000, 3'b000);
            send(1'b0, 8'd128, 28'hC00_0000, 1'b0, 32'h4040_0000, 3'b000);
         end
      join
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      check("stream_drain", 32'(exp_q.size()), 32'd0);

      // Reset with two results in flight
      @(posedge clk) #1 i_ready = 1'b0;
      send(1'b0, 8'd127, 28'h400_0000, 1'b0, 32'h3F00_0000, 3'b000);
      send(1'b0, 8'd127, 28'h000_0000, 1'b1, 32'h4000_0000, 3'b000);
      check("inflight_o_valid", 32'(o_valid), 32'd1);
      #1 rst = 1'b1;
      #1 check("rst_mid_o_valid", 32'(o_valid), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      i_ready = 1'b1;
      count_post = 1'b1;
      repeat (10) @(negedge clk);
      count_post = 1'b0;
      check("no_out_after_rst", 32'(post_rst_outs), 32'd0);
      check("post_rst_o_ready", 32'(o_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
